multibank_write_ctrl: RTL
=========================

# multibank_write_ctrl

Parametrised write-side controller for a multi-bank dual-port frame buffer. It generalises the two-bank ping-pong write controller to BANKS banks of DEPTH words each. It accepts variable-length frames ended by `din_last` or by the bank filling up, and publishes each committed bank to the read side with its length. When no free bank exists it drops words and counts the losses. It sits between the input source and the dual-port RAM write port, and its `status_vld` / `r_done` handshake goes to the read controller.

## Interface
- `DATA_W`, default 8: data width.
- `BANKS`, default 4: number of banks. Must be ≥2 and a power of 2.
- `DEPTH`, default 16: words per bank. Must be a power of 2 and ≥2.
- `DROP_W`, default 16: width of the drop counter.
- `ADDR_W` (derived) = clog2(BANKS) + clog2(DEPTH). `LEN_W` (derived) = clog2(DEPTH)+1.
- `clk`, in, 1: single clock. All logic is clocked on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `din`, in, DATA_W: input word.
- `din_vld`, in, 1: input word valid. Single-cycle qualifier; there is no backpressure on the source.
- `din_last`, in, 1: marks the final word of a frame. Qualified by `din_vld`.
- `din_rdy`, out, 1: combinational; equals ~status_vld[wr_bank]. Advisory only.
- `r_done`, in, BANKS: one-hot or multi-hot pulse from the reader releasing banks.
- `w_en`, out, 1: RAM write enable.
- `w_addr`, out, ADDR_W: RAM write address = {wr_bank_at_accept, offset}.
- `w_data`, out, DATA_W: RAM write data.
- `status_vld`, out, BANKS: bank b holds a committed frame.
- `bank_len`, out, BANKS*LEN_W: flattened lengths, bank b at [b*LEN_W +: LEN_W]. Valid while status_vld[b]=1.
- `full`, out, 1: registered; equals &status_vld.
- `wr_bank`, out, clog2(BANKS): bank currently being filled.
- `ovf`, out, 1: one-cycle pulse per dropped word.
- `drop_cnt`, out, DROP_W: saturating count of dropped words.

## Operation
- Accept condition: `din_vld` && ~status_vld[wr_bank].
- On accept:
  - the word is written at `offset` of `wr_bank`;
  - `offset` increments.
- Commit condition: accept && (`din_last` || offset==DEPTH-1). On commit:
  - record len = offset+1 for the bank;
  - `offset` returns to 0;
  - `wr_bank` advances to (wr_bank+1) mod BANKS. Wrap from BANKS-1 goes to 0.
  - The bank's status_vld bit rises one cycle late (see Timing).
- Word-count rules:
  - `din_last` on the first word gives len=1.
  - A full bank gives len=DEPTH. LEN_W is wide enough to hold DEPTH without overflow.
- Fill state machine, reported via `din_rdy`:
  - FILL: status_vld[wr_bank]=0. Words are accepted.
  - HOLD: status_vld[wr_bank]=1. Every `din_vld` is dropped: `ovf`=1 for that cycle, and drop_cnt increments, saturating at 2^DROP_W-1.
  - HOLD→FILL on the cycle after the reader clears status_vld[wr_bank].
  - Dropped words never advance `offset` or `wr_bank`.
- Status update: next status_vld = (status_vld & ~r_done) | commit_mask_delayed.
  - r_done bits on banks whose status_vld is 0 are ignored.
  - If r_done and a delayed commit hit the same bank in the same cycle, the commit wins.
  - r_done and din_vld in the same cycle are both processed. Release is not blocked by writes.
- `bank_len[b]` updates only on commit of bank b. It holds its value after release.

## Timing
- `w_en`, `w_addr` and `w_data` are registered. They assert exactly one cycle after the accepting `din_vld` edge. `w_en` is low in all other cycles.
- `status_vld[b]` rises one cycle after the `w_en` pulse of the final word, i.e. 2 cycles after the final `din_vld`. The reader therefore never sees a bank before its last RAM write has completed.
- A `r_done` pulse at edge N clears status_vld at edge N. `din_rdy` and acceptance reflect the cleared bit in cycle N+1.
- `full` follows status_vld with zero extra latency; it is registered from the same next-state value.
- Back-to-back accepts run at 1 word/cycle, including across a commit into a free next bank.
- Reset values: w_en=0, w_addr=0, w_data=0, status_vld=0, bank_len=0, full=0, wr_bank=0, offset=0, ovf=0, drop_cnt=0. The pending delayed commit is also cleared.
- Reset asserted mid-frame discards the partial frame. The first word after reset goes to address 0.

## Test plan
- Reset then idle 10 cycles: every output is 0 and din_rdy=1.
- BANKS=4, DEPTH=4, four consecutive words A0..A3 with no last: w_addr=0,1,2,3 on consecutive cycles; status_vld=0001 two cycles after A3; len0=4; wr_bank=1.
- Words B0, B1 with din_last on B1, then C0: len1=2; status_vld[1] set; C0 written at w_addr=8 (bank2, offset0).
- Fill all 4 banks, then 3 din_vld: full=1, din_rdy=0, no w_en, ovf pulses ×3, drop_cnt=3. Then r_done=0001: status_vld=1110 the next cycle, full=0, and the next word is written at w_addr=0.
- r_done[1] pulsed while bank1 is invalid, in the same cycle as the delayed commit of bank1: status_vld[1]=1 (commit wins). r_done[2] pulsed on an invalid bank2: no effect.
- DROP_W=2, 5 drops: drop_cnt=3 (saturated). Then assert rst mid-frame at offset 2: everything returns to 0 and the next word is written at w_addr=0.

Source files
------------

// File: rtl/multibank_write_ctrl.sv
// Write-side controller for a BANKS-way multi-bank frame buffer: fills banks in rotation,
// publishes committed banks with their lengths, and drops/counts words when no bank is free.
module multibank_write_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BANKS  = 4,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DROP_W = 16,
  localparam int unsigned BANK_W = $clog2(BANKS),
  localparam int unsigned OFF_W  = $clog2(DEPTH),
  localparam int unsigned ADDR_W = BANK_W + OFF_W,
  localparam int unsigned LEN_W  = OFF_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      din,
  input  logic                   din_vld,
  input  logic                   din_last,
  output logic                   din_rdy,
  input  logic [BANKS-1:0]       r_done,
  output logic                   w_en,
  output logic [ADDR_W-1:0]      w_addr,
  output logic [DATA_W-1:0]      w_data,
  output logic [BANKS-1:0]       status_vld,
  output logic [BANKS*LEN_W-1:0] bank_len,
  output logic                   full,
  output logic [BANK_W-1:0]      wr_bank,
  output logic                   ovf,
  output logic [DROP_W-1:0]      drop_cnt
);

  logic [BANK_W-1:0] wr_bank_q;
  logic [OFF_W-1:0]  offset_q;
  logic [BANKS-1:0]  status_q, status_d, commit_mask;
  logic [LEN_W-1:0]  len_q [BANKS];
  logic              pend_vld_q;
  logic [BANK_W-1:0] pend_bank_q;
  logic              w_en_q, ovf_q, full_q;
  logic [ADDR_W-1:0] w_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [DROP_W-1:0] drop_cnt_q;
  logic              accept, commit, drop;

  always_comb begin
    din_rdy = ~status_q[wr_bank_q];
    accept  = din_vld & din_rdy;
    drop    = din_vld & ~din_rdy;
    commit  = accept & (din_last | (offset_q == OFF_W'(DEPTH - 1)));
    // Commit is published one cycle after its RAM write so the reader never races it.
    commit_mask = '0;
    if (pend_vld_q) commit_mask[pend_bank_q] = 1'b1;
    status_d = (status_q & ~r_done) | commit_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q   <= '0;
      offset_q    <= '0;
      status_q    <= '0;
      full_q      <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_bank_q <= '0;
      w_en_q      <= 1'b0;
      w_addr_q    <= '0;
      w_data_q    <= '0;
      ovf_q       <= 1'b0;
      drop_cnt_q  <= '0;
      for (int b = 0; b < BANKS; b++) len_q[b] <= '0;
    end else begin
      w_en_q <= accept;
      if (accept) begin
        w_addr_q <= {wr_bank_q, offset_q};
        w_data_q <= din;
      end
      if (commit) begin
        len_q[wr_bank_q] <= LEN_W'(offset_q) + LEN_W'(1);
        offset_q         <= '0;
        wr_bank_q        <= wr_bank_q + BANK_W'(1);
      end else if (accept) begin
        offset_q <= offset_q + OFF_W'(1);
      end
      pend_vld_q  <= commit;
      pend_bank_q <= wr_bank_q;
      status_q    <= status_d;
      full_q      <= &status_d;
      ovf_q       <= drop;
      if (drop && (drop_cnt_q != {DROP_W{1'b1}})) drop_cnt_q <= drop_cnt_q + DROP_W'(1);
    end
  end

  always_comb begin
    bank_len = '0;
    for (int b = 0; b < BANKS; b++) bank_len[b*LEN_W +: LEN_W] = len_q[b];
  end

  assign w_en       = w_en_q;
  assign w_addr     = w_addr_q;
  assign w_data     = w_data_q;
  assign status_vld = status_q;
  assign full       = full_q;
  assign wr_bank    = wr_bank_q;
  assign ovf        = ovf_q;
  assign drop_cnt   = drop_cnt_q;

endmodule
